// File: rtl/dmem_responder.sv
// Memory-side responder for the core's RV32I load/store port: one request at a time,
// programmable wait states, byte/half/word access. Optional DMEM_ERR_EN adds fault reporting.
module dmem_responder #(
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    // state  | meaning
    // S_IDLE | ready for a request
    // S_WAIT | counting wait states, access on count==1
    // S_RESP | response held until rsp_ready
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic [3:0]    count;
    logic          lat_we;
    logic [LW-1:0] lat_addr;
    logic [31:0]   lat_wdata;
    logic [2:0]    lat_funct3;
    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          access;
    logic          a_we;
    logic [LW-1:0] a_addr;
    logic [31:0]   a_wdata;
    logic [2:0]    a_funct3;
    logic [AW-1:0] a_idx;
    logic [31:0]   cur_word;
    logic [31:0]   lane_b;
    logic [31:0]   lane_h;
    logic [31:0]   load_data;
    logic [31:0]   st_mask;
    logic [31:0]   st_data;
    logic [31:0]   new_word;
    logic          acc_err;
    logic          unused_addr;

    assign unused_addr = ^req_addr[31:LW];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        access    = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_INIT == 4'd0) begin
                        access    = 1'b1;
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (count == 4'd1) begin
                    access    = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // With zero wait states the access happens on the accept edge, so use the live request.
    always_comb begin
        if (state == S_IDLE) begin
            a_we     = req_we;
            a_addr   = req_addr[LW-1:0];
            a_wdata  = req_wdata;
            a_funct3 = req_funct3;
        end else begin
            a_we     = lat_we;
            a_addr   = lat_addr;
            a_wdata  = lat_wdata;
            a_funct3 = lat_funct3;
        end
    end

    assign a_idx    = a_addr[LW-1:2];
    assign cur_word = mem[a_idx];
    assign lane_b   = cur_word >> {a_addr[1:0], 3'b000};
    assign lane_h   = cur_word >> {a_addr[1], 4'b0000};

    always_comb begin
        load_data = cur_word;
        st_mask   = 32'hFFFF_FFFF;
        st_data   = a_wdata;
        case (a_funct3)
            3'b000: load_data = {{24{lane_b[7]}}, lane_b[7:0]};
            3'b100: load_data = {24'h0, lane_b[7:0]};
            3'b001: load_data = {{16{lane_h[15]}}, lane_h[15:0]};
            3'b101: load_data = {16'h0, lane_h[15:0]};
            default: load_data = cur_word;
        endcase
        case (a_funct3)
            3'b000, 3'b100: begin
                st_mask = 32'h0000_00FF << {a_addr[1:0], 3'b000};
                st_data = {24'h0, a_wdata[7:0]} << {a_addr[1:0], 3'b000};
            end
            3'b001, 3'b101: begin
                st_mask = 32'h0000_FFFF << {a_addr[1], 4'b0000};
                st_data = {16'h0, a_wdata[15:0]} << {a_addr[1], 4'b0000};
            end
            default: begin
                st_mask = 32'hFFFF_FFFF;
                st_data = a_wdata;
            end
        endcase
    end

    assign new_word = (cur_word & ~st_mask) | (st_data & st_mask);

`ifdef DMEM_ERR_EN
    always_comb begin
        acc_err = 1'b0;
        case (a_funct3)
            3'b001, 3'b101:         acc_err = a_addr[0];
            3'b010:                 acc_err = |a_addr[1:0];
            3'b011, 3'b110, 3'b111: acc_err = 1'b1;
            default:                acc_err = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        rsp_err <= 1'b0;
        else if (access) rsp_err <= acc_err;
    end
`else
    assign acc_err = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= 4'd0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= 32'h0;
            lat_funct3 <= 3'b000;
            rsp_rdata  <= 32'h0;
        end else begin
            if (accept) begin
                count      <= WAIT_INIT;
                lat_we     <= req_we;
                lat_addr   <= req_addr[LW-1:0];
                lat_wdata  <= req_wdata;
                lat_funct3 <= req_funct3;
            end else if (state == S_WAIT) begin
                count <= count - 4'd1;
            end
            if (access) rsp_rdata <= (a_we || acc_err) ? 32'h0 : load_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
        end else if (access && a_we && !acc_err) begin
            mem[a_idx] <= new_word;
        end
    end

endmodule
